// File: rtl/edk_mem_seq_pkg.sv
// edk_mem_seq_pkg
// Shared widths and the one-hot state encoding for the SRAM access sequencer.
//   DWIDTH  : host/SRAM data width
//   AWIDTH  : address width (matches the address controller output)
//   BSWIDTH : width of the one-hot sequencer state vector
//   CWIDTH  : width of the wait-state down-counter
package edk_mem_seq_pkg;

    localparam int DWIDTH  = 8;
    localparam int AWIDTH  = 17;
    localparam int BSWIDTH = 5;
    localparam int CWIDTH  = 4;

    typedef enum logic [BSWIDTH-1:0] {
        ST_IDLE   = 5'b00001,
        ST_SETUP  = 5'b00010,
        ST_ACCESS = 5'b00100,
        ST_HOLD   = 5'b01000,
        ST_INC    = 5'b10000
    } seq_state_t;

endpackage

// File: rtl/edk_mem_seq_if.sv
// edk_mem_seq_if
// Groups the host request side and the SRAM side of the sequencer.
//   slave  : the sequencer (takes requests and mem_din, drives status and SRAM pins)
//   master : the host/SRAM environment (drives requests and mem_din)
interface edk_mem_seq_if;
    import edk_mem_seq_pkg::*;

    // host side
    logic [AWIDTH-1:0] addr_in;
    logic              rd_req;
    logic              wr_req;
    logic [DWIDTH-1:0] wr_data;
    logic              auto_inc;
    logic              ovr_clr;
    logic              busy;
    logic [DWIDTH-1:0] rd_data;
    logic              rd_valid;
    logic              overrun;
    logic              inc_strb_n;
    logic              inc_en;
    // SRAM side
    logic [AWIDTH-1:0] mem_addr;
    logic              mem_ce_n;
    logic              mem_oe_n;
    logic              mem_we_n;
    logic [DWIDTH-1:0] mem_dout;
    logic              mem_doe;
    logic [DWIDTH-1:0] mem_din;

    modport slave (
        input  addr_in, rd_req, wr_req, wr_data, auto_inc, ovr_clr, mem_din,
        output busy, rd_data, rd_valid, overrun, inc_strb_n, inc_en,
               mem_addr, mem_ce_n, mem_oe_n, mem_we_n, mem_dout, mem_doe
    );

    modport master (
        output addr_in, rd_req, wr_req, wr_data, auto_inc, ovr_clr, mem_din,
        input  busy, rd_data, rd_valid, overrun, inc_strb_n, inc_en,
               mem_addr, mem_ce_n, mem_oe_n, mem_we_n, mem_dout, mem_doe
    );

endinterface

// File: rtl/edk_wait_cnt.sv
// edk_wait_cnt
// Loadable 4-bit down-counter with zero flag; times the ACCESS phase.
//   clk, ACTL_RstN : clock, asynchronous active-low reset
//   load, load_val : load the count (has priority over dec)
//   dec            : decrement, saturating at zero
//   zero           : count is zero
module edk_wait_cnt
    import edk_mem_seq_pkg::*;
(
    input  logic              clk,
    input  logic              ACTL_RstN,
    input  logic              load,
    input  logic [CWIDTH-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [CWIDTH-1:0] cnt_reg;

    always_ff @(posedge clk or negedge ACTL_RstN) begin
        if (!ACTL_RstN) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/edk_mem_seq.sv
// edk_mem_seq
// Runs complete SRAM read/write cycles with programmable wait states for
// single-cycle host requests, captures read data, and optionally emits the
// address-controller increment strobe pair after each access.
//   clk, ACTL_RstN : clock, asynchronous active-low reset
//   bus (slave)    : host requests/status and SRAM pins, see edk_mem_seq_if
//   WAIT_CYCLES    : ACCESS phase length in clocks (1..15)
//
// SRAM and strobe pins are registered decodes of the current state, so each
// pin phase trails its state by one clock. busy therefore stays high for one
// extra clock after the FSM returns to IDLE, covering the trailing HOLD (or
// INC) pin phase; a request is accepted only when idle and not busy.
module edk_mem_seq
    import edk_mem_seq_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic ACTL_RstN,
    edk_mem_seq_if.slave bus
);

    seq_state_t state_reg, state_next;

    logic              busy_reg, rd_valid_reg, overrun_reg;
    logic [DWIDTH-1:0] rd_data_reg, mem_dout_reg;
    logic [AWIDTH-1:0] mem_addr_reg;
    logic              op_wr_reg, inc_reg;
    logic              ce_n_reg, oe_n_reg, we_n_reg, doe_reg;
    logic              inc_strb_n_reg, inc_en_reg;

    logic ce_n_next, oe_n_next, we_n_next, doe_next;
    logic inc_strb_n_next, inc_en_next;
    logic any_req, accept, ovr_set;
    logic cnt_load, cnt_dec, cnt_zero;

    edk_wait_cnt u_wait_cnt (
        .clk       (clk),
        .ACTL_RstN (ACTL_RstN),
        .load      (cnt_load),
        .load_val  (4'(WAIT_CYCLES - 1)),
        .dec       (cnt_dec),
        .zero      (cnt_zero)
    );

    always_comb begin
        state_next      = state_reg;
        cnt_load        = 1'b0;
        cnt_dec         = 1'b0;
        any_req         = bus.rd_req | bus.wr_req;
        accept          = (state_reg == ST_IDLE) && !busy_reg && any_req;
        // a request while busy, or the read half of a simultaneous pair
        ovr_set         = (any_req && !accept) || (accept && bus.rd_req && bus.wr_req);

        unique case (state_reg)
            ST_IDLE:   if (accept) state_next = ST_SETUP;
            ST_SETUP: begin
                cnt_load   = 1'b1;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_zero) state_next = ST_HOLD;
                else          cnt_dec    = 1'b1;
            end
            ST_HOLD:   state_next = inc_reg ? ST_INC : ST_IDLE;
            ST_INC:    state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase

        ce_n_next       = !((state_reg == ST_SETUP) || (state_reg == ST_ACCESS) ||
                            (state_reg == ST_HOLD));
        oe_n_next       = !(!op_wr_reg && ((state_reg == ST_SETUP) || (state_reg == ST_ACCESS)));
        we_n_next       = !(op_wr_reg && (state_reg == ST_ACCESS));
        doe_next        = op_wr_reg && !ce_n_next;
        inc_strb_n_next = !(state_reg == ST_INC);
        // qualifier covers the low strobe and the clock of its rising edge
        inc_en_next     = (state_reg == ST_INC) || !inc_strb_n_reg;
    end

    always_ff @(posedge clk or negedge ACTL_RstN) begin
        if (!ACTL_RstN) begin
            state_reg      <= ST_IDLE;
            busy_reg       <= 1'b0;
            rd_valid_reg   <= 1'b0;
            overrun_reg    <= 1'b0;
            rd_data_reg    <= '0;
            mem_addr_reg   <= '0;
            mem_dout_reg   <= '0;
            op_wr_reg      <= 1'b0;
            inc_reg        <= 1'b0;
            ce_n_reg       <= 1'b1;
            oe_n_reg       <= 1'b1;
            we_n_reg       <= 1'b1;
            doe_reg        <= 1'b0;
            inc_strb_n_reg <= 1'b1;
            inc_en_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ce_n_reg       <= ce_n_next;
            oe_n_reg       <= oe_n_next;
            we_n_reg       <= we_n_next;
            doe_reg        <= doe_next;
            inc_strb_n_reg <= inc_strb_n_next;
            inc_en_reg     <= inc_en_next;

            if (accept) begin
                mem_addr_reg <= bus.addr_in;
                op_wr_reg    <= bus.wr_req;
                inc_reg      <= bus.auto_inc;
                busy_reg     <= 1'b1;
                rd_valid_reg <= 1'b0;
                if (bus.wr_req) mem_dout_reg <= bus.wr_data;
            end else if (state_reg == ST_IDLE) begin
                busy_reg <= 1'b0;
            end

            // oe_n is still low at this edge: the last edge of the read strobe
            if ((state_reg == ST_HOLD) && !op_wr_reg) begin
                rd_data_reg  <= bus.mem_din;
                rd_valid_reg <= 1'b1;
            end

            if (bus.ovr_clr)  overrun_reg <= 1'b0;
            else if (ovr_set) overrun_reg <= 1'b1;
        end
    end

    assign bus.busy       = busy_reg;
    assign bus.rd_data    = rd_data_reg;
    assign bus.rd_valid   = rd_valid_reg;
    assign bus.overrun    = overrun_reg;
    assign bus.inc_strb_n = inc_strb_n_reg;
    assign bus.inc_en     = inc_en_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_ce_n   = ce_n_reg;
    assign bus.mem_oe_n   = oe_n_reg;
    assign bus.mem_we_n   = we_n_reg;
    assign bus.mem_dout   = mem_dout_reg;
    assign bus.mem_doe    = doe_reg;

endmodule

// File: tb/tb_edk_mem_seq.sv
// tb_edk_mem_seq
// Directed bench for edk_mem_seq with WAIT_CYCLES=2. Each access is traced
// for L clocks; trace index i holds the outputs seen after request edge N+i.
module tb_edk_mem_seq;
    import edk_mem_seq_pkg::*;

    localparam int W = 2;
    localparam int L = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    edk_mem_seq_if bus();

    edk_mem_seq #(.WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .ACTL_RstN (rst_n),
        .bus       (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [L-1:0] tr_busy, tr_rv, tr_oe_n, tr_we_n, tr_doe, tr_strb_n, tr_inc_en;
    int addr_bad, dout_bad, inc_rise_ok;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [AWIDTH-1:0] a,
                         input logic [DWIDTH-1:0] d, input logic inc);
        bus.rd_req   = rd;
        bus.wr_req   = wr;
        bus.addr_in  = a;
        bus.wr_data  = d;
        bus.auto_inc = inc;
        @(posedge clk); #1;
        bus.rd_req   = 1'b0;
        bus.wr_req   = 1'b0;
        bus.wr_data  = '0;
        bus.auto_inc = 1'b0;
    endtask

    // inj_at >= 0 drives a stray rd_req (with ovr_clr = inj_clr) into edge N+inj_at+2
    task automatic run_trace(input int inj_at, input logic inj_clr,
                             input logic [AWIDTH-1:0] exp_addr, input logic [DWIDTH-1:0] exp_dout);
        logic prev_strb;
        prev_strb   = 1'b1;
        addr_bad    = 0;
        dout_bad    = 0;
        inc_rise_ok = 0;
        for (int i = 0; i < L; i++) begin
            @(negedge clk);
            tr_busy[i]   = bus.busy;
            tr_rv[i]     = bus.rd_valid;
            tr_oe_n[i]   = bus.mem_oe_n;
            tr_we_n[i]   = bus.mem_we_n;
            tr_doe[i]    = bus.mem_doe;
            tr_strb_n[i] = bus.inc_strb_n;
            tr_inc_en[i] = bus.inc_en;
            if (!bus.mem_ce_n && bus.mem_addr !== exp_addr) addr_bad++;
            if (bus.mem_doe && bus.mem_dout !== exp_dout) dout_bad++;
            if (!prev_strb && bus.inc_strb_n && bus.inc_en) inc_rise_ok++;
            prev_strb = bus.inc_strb_n;
            @(posedge clk); #1;
            if (i == inj_at) begin
                bus.rd_req  = 1'b1;
                bus.addr_in = 17'h1FFFF;
                bus.ovr_clr = inj_clr;
            end else begin
                bus.rd_req  = 1'b0;
                bus.ovr_clr = 1'b0;
            end
        end
    endtask

    task automatic pulse_ovr_clr();
        bus.ovr_clr = 1'b1;
        @(posedge clk); #1;
        bus.ovr_clr = 1'b0;
    endtask

    initial begin
        int dev;
        int strb_lows;
        bus.addr_in  = '0;
        bus.rd_req   = 1'b0;
        bus.wr_req   = 1'b0;
        bus.wr_data  = '0;
        bus.auto_inc = 1'b0;
        bus.ovr_clr  = 1'b0;
        bus.mem_din  = '0;

        // asynchronous reset, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_busy",   32'(bus.busy),       32'h0);
        check_val("rst_ce_n",   32'(bus.mem_ce_n),   32'h1);
        check_val("rst_strb_n", 32'(bus.inc_strb_n), 32'h1);
        check_val("rst_addr",   32'(bus.mem_addr),   32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        $display("[TB] reset released");

        // idle: every output holds its reset value for 20 clocks
        dev = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.overrun !== 1'b0) dev++;
            if (bus.rd_data !== '0 || bus.mem_addr !== '0 || bus.mem_dout !== '0) dev++;
            if (bus.mem_ce_n !== 1'b1 || bus.mem_oe_n !== 1'b1 || bus.mem_we_n !== 1'b1) dev++;
            if (bus.mem_doe !== 1'b0 || bus.inc_strb_n !== 1'b1 || bus.inc_en !== 1'b0) dev++;
        end
        check_val("idle20_dev", 32'(dev), 32'h0);
        @(posedge clk); #1;

        // read, no increment
        bus.mem_din = 8'h5A;
        issue(1'b1, 1'b0, 17'h1ABCD, 8'h00, 1'b0);
        run_trace(-1, 1'b0, 17'h1ABCD, 8'h00);
        $display("[TB] read 0x1ABCD -> rd_data 0x%0h", bus.rd_data);
        check_val("rd_busy0",     32'(tr_busy[0]),           32'h1);
        check_val("rd_addr",      32'(addr_bad),             32'h0);
        check_val("rd_oe_cnt",    32'($countones(~tr_oe_n)), 32'h3);
        check_val("rd_oe_start",  32'(tr_oe_n[1:0]),         32'h1);
        check_val("rd_we_cnt",    32'($countones(~tr_we_n)), 32'h0);
        check_val("rd_valid_pre", 32'(tr_rv[3]),             32'h0);
        check_val("rd_valid_at",  32'(tr_rv[4]),             32'h1);
        check_val("rd_busy_fall", 32'(tr_busy[5:4]),         32'h1);
        check_val("rd_data",      32'(bus.rd_data),          32'h5A);
        check_val("rd_no_strb",   32'($countones(~tr_strb_n)), 32'h0);

        // write with auto increment
        issue(1'b0, 1'b1, 17'h00F0F, 8'hC3, 1'b1);
        run_trace(-1, 1'b0, 17'h00F0F, 8'hC3);
        $display("[TB] write 0xC3 -> 0x00F0F with auto_inc");
        check_val("wr_rv_clear",  32'(tr_rv[0]),               32'h0);
        check_val("wr_we_cnt",    32'($countones(~tr_we_n)),   32'h2);
        check_val("wr_we_win",    32'(tr_we_n[4:1]),           32'h9);
        check_val("wr_doe_cnt",   32'($countones(tr_doe)),     32'h4);
        check_val("wr_dout",      32'(dout_bad),               32'h0);
        check_val("wr_addr",      32'(addr_bad),               32'h0);
        check_val("wr_oe_cnt",    32'($countones(~tr_oe_n)),   32'h0);
        check_val("wr_strb_cnt",  32'($countones(~tr_strb_n)), 32'h1);
        check_val("wr_strb_pos",  32'(tr_strb_n[5]),           32'h0);
        check_val("wr_inc_rise",  32'(inc_rise_ok),            32'h1);
        check_val("wr_inc_en",    32'(tr_inc_en[7:5]),         32'h3);
        check_val("wr_busy_fall", 32'(tr_busy[6:5]),           32'h1);

        // simultaneous read and write: write only, overrun set
        issue(1'b1, 1'b1, 17'h00055, 8'h3C, 1'b0);
        run_trace(-1, 1'b0, 17'h00055, 8'h3C);
        $display("[TB] rd+wr collision -> overrun %0b", bus.overrun);
        check_val("col_we_cnt",  32'($countones(~tr_we_n)), 32'h2);
        check_val("col_oe_cnt",  32'($countones(~tr_oe_n)), 32'h0);
        check_val("col_dout",    32'(dout_bad),             32'h0);
        check_val("col_overrun", 32'(bus.overrun),          32'h1);
        pulse_ovr_clr();
        check_val("col_ovr_clr", 32'(bus.overrun),          32'h0);

        // read with a stray request while busy
        bus.mem_din = 8'h77;
        issue(1'b1, 1'b0, 17'h00123, 8'h00, 1'b0);
        run_trace(0, 1'b0, 17'h00123, 8'h00);
        $display("[TB] read 0x00123 with stray rd_req -> rd_data 0x%0h", bus.rd_data);
        check_val("bz_overrun", 32'(bus.overrun),          32'h1);
        check_val("bz_addr",    32'(addr_bad),             32'h0);
        check_val("bz_oe_cnt",  32'($countones(~tr_oe_n)), 32'h3);
        check_val("bz_rd_data", 32'(bus.rd_data),          32'h77);
        check_val("bz_busy",    32'(tr_busy[5:4]),         32'h1);
        pulse_ovr_clr();
        check_val("bz_ovr_clr", 32'(bus.overrun),          32'h0);

        // ovr_clr together with a stray request: clear wins
        bus.mem_din = 8'h11;
        issue(1'b1, 1'b0, 17'h00200, 8'h00, 1'b0);
        run_trace(1, 1'b1, 17'h00200, 8'h00);
        $display("[TB] stray rd_req with ovr_clr -> overrun %0b", bus.overrun);
        check_val("clr_wins",   32'(bus.overrun), 32'h0);
        check_val("clr_rd",     32'(bus.rd_data), 32'h11);

        // reset during ACCESS of an auto-increment write
        issue(1'b0, 1'b1, 17'h01111, 8'hA5, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("rst_mid_we_lo", 32'(bus.mem_we_n), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        $display("[TB] reset asserted during write ACCESS");
        check_val("rst_mid_we_n", 32'(bus.mem_we_n), 32'h1);
        check_val("rst_mid_ce_n", 32'(bus.mem_ce_n), 32'h1);
        check_val("rst_mid_doe",  32'(bus.mem_doe),  32'h0);
        check_val("rst_mid_busy", 32'(bus.busy),     32'h0);
        strb_lows = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (!bus.inc_strb_n || bus.inc_en) strb_lows++;
        end
        check_val("rst_mid_no_inc", 32'(strb_lows), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
